// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU-side memory/IO bus controller.
// Decodes CPU loads/stores onto a synchronous-read RAM and a small I/O page
// (LED register, switch inputs, free-running timer). A three-state handshake
// FSM paces the CPU through MIO_ready: stores finish in 1 cycle, loads in 2.
module mio_bus_ctrl #(
   parameter int          RAM_AW  = 10,
   parameter logic [31:0] IO_BASE = 32'hE000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_w,
   input  logic              mem_rd,
   input  logic [31:0]       Addr_in,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        DMWType,
   output logic [31:0]       cpu_rdata,
   output logic              MIO_ready,
   output logic              err_misalign,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [3:0]        ram_we,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_ACK     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [15:0] sw_meta_q, sw_sync_q;

   logic        ram_sel_s;
   logic        io_page_s;
   logic        led_sel_s;
   logic        sw_sel_s;
   logic        tmr_sel_s;
   logic        mis_s;
   logic        store_go_s;
   logic [31:0] rd_sel_s;

   // The RAM sees the word address straight from the CPU so that the
   // synchronous read data is ready in the RD_WAIT cycle.
   assign ram_addr = Addr_in[RAM_AW+1:2];

   // Address decode, alignment check and the single-cycle store strobe.
   always_comb begin
      ram_sel_s  = (Addr_in[31:RAM_AW+2] == {(30-RAM_AW){1'b0}});
      io_page_s  = (Addr_in[31:12] == IO_BASE[31:12]);
      led_sel_s  = io_page_s && (Addr_in[11:2] == 10'h000);
      sw_sel_s   = io_page_s && (Addr_in[11:2] == 10'h001);
      tmr_sel_s  = io_page_s && (Addr_in[11:2] == 10'h002);
      mis_s      = ((DMWType == 4'b0011) && Addr_in[0]) ||
                   ((DMWType == 4'b1111) && (Addr_in[1:0] != 2'b00));
      // Stores take effect only in the IDLE request cycle and never in reset.
      store_go_s = reset && (state_q == ST_IDLE) && mem_w && !mis_s;
   end

   // Load data selection; RAM word is shifted so the addressed lane lands at bit 0.
   always_comb begin
      rd_sel_s = 32'h0000_0000;
      if (ram_sel_s) begin
         rd_sel_s = ram_rdata >> {Addr_in[1:0], 3'b000};
      end else if (led_sel_s) begin
         rd_sel_s = {16'h0000, led_q};
      end else if (sw_sel_s) begin
         rd_sel_s = {16'h0000, sw_sync_q};
      end else if (tmr_sel_s) begin
         rd_sel_s = timer_q;
      end else begin
         rd_sel_s = 32'h0000_0000;
      end
   end

   // RAM byte enables and lane-replicated write data.
   always_comb begin
      ram_we = 4'b0000;
      if (store_go_s && ram_sel_s) begin
         ram_we = DMWType << Addr_in[1:0];
      end else begin
         ram_we = 4'b0000;
      end
      case (DMWType)
         4'b0001: ram_wdata = {4{cpu_wdata[7:0]}};
         4'b0011: ram_wdata = {2{cpu_wdata[15:0]}};
         default: ram_wdata = cpu_wdata;
      endcase
   end

   // Handshake FSM next state plus read-data capture and misalign flag.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_w) begin
               // A store wins when both requests are raised together.
               state_d = ST_ACK;
               err_d   = mis_s;
            end else if (mem_rd) begin
               state_d = ST_RD_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            state_d = ST_ACK;
            err_d   = mis_s;
            if (mis_s) begin
               rdata_d = 32'h0000_0000;
            end else begin
               rdata_d = rd_sel_s;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // LED register and timer next values; a timer store overrides the increment.
   always_comb begin
      led_d   = led_q;
      timer_d = timer_q + 32'd1;
      if (store_go_s && led_sel_s) begin
         led_d = cpu_wdata[15:0];
      end else begin
         led_d = led_q;
      end
      if (store_go_s && tmr_sel_s) begin
         timer_d = cpu_wdata;
      end else begin
         timer_d = timer_q + 32'd1;
      end
   end

   // State, data and synchronizer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         led_q     <= 16'h0000;
         timer_q   <= 32'h0000_0000;
         rdata_q   <= 32'h0000_0000;
         err_q     <= 1'b0;
         sw_meta_q <= 16'h0000;
         sw_sync_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   assign MIO_ready    = (state_q == ST_ACK) ||
                         ((state_q == ST_IDLE) && !mem_w && !mem_rd);
   assign cpu_rdata    = rdata_q;
   assign err_misalign = err_q;
   assign led_out      = led_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// tb_mio_bus_ctrl: scoreboard bench for mio_bus_ctrl with a behavioural
// synchronous RAM attached to the RAM port.
module tb_mio_bus_ctrl;

   localparam logic [31:0] IOB = 32'hE000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_w, mem_rd;
   logic [31:0] Addr_in, cpu_wdata;
   logic [3:0]  DMWType;
   logic [31:0] cpu_rdata;
   logic        MIO_ready, err_misalign;
   logic [9:0]  ram_addr;
   logic [3:0]  ram_we;
   logic [31:0] ram_wdata, ram_rdata;
   logic [15:0] sw_in, led_out;

   always #5 clk = ~clk;

   mio_bus_ctrl #(.RAM_AW(10), .IO_BASE(IOB)) dut (
      .clk(clk), .reset(reset), .mem_w(mem_w), .mem_rd(mem_rd),
      .Addr_in(Addr_in), .cpu_wdata(cpu_wdata), .DMWType(DMWType),
      .cpu_rdata(cpu_rdata), .MIO_ready(MIO_ready), .err_misalign(err_misalign),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out)
   );

   // Behavioural synchronous-read RAM.
   logic [31:0] ram_mem [0:1023];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= ram_mem[ram_addr];
   end

   // Edge counter used to predict the timer value.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      int          lat;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // Reference model state.
   logic [31:0] exp_mem [0:1023];
   logic [15:0] led_m, sw_m;
   logic [31:0] tmr_val;
   int          tmr_edge;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // One complete CPU access: predict, drive, wait for MIO_ready, compare.
   task automatic access(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] sz);
      exp_t        e;
      logic        mis;
      logic        is_ram;
      logic [3:0]  we_e;
      int          off, nb, n;
      bit          rdy;
      @(negedge clk);
      off    = int'(addr[1:0]);
      nb     = (sz == 4'b0001) ? 1 : (sz == 4'b0011) ? 2 : 4;
      mis    = ((sz == 4'b0011) && addr[0]) || ((sz == 4'b1111) && (addr[1:0] != 2'b00));
      is_ram = (addr[31:12] == 20'h00000);
      we_e   = 4'b0000;
      e.lat  = wr ? 1 : 2;
      e.err  = mis;
      e.rdata = 32'h0000_0000;
      if (wr && !mis) begin
         if (is_ram) begin
            for (int b = 0; b < 4; b++) begin
               if (b >= off && b < off + nb) begin
                  we_e[b] = 1'b1;
                  exp_mem[addr[11:2]][8*b +: 8] = wd[8*(b-off) +: 8];
               end
            end
         end else if (addr == IOB) begin
            led_m = wd[15:0];
         end else if (addr == IOB + 32'd8) begin
            tmr_val  = wd;
            tmr_edge = cyc + 1;
         end
      end
      if (!wr && !mis) begin
         if (is_ram)                     e.rdata = exp_mem[addr[11:2]] >> (8*off);
         else if (addr == IOB)           e.rdata = {16'h0000, led_m};
         else if (addr == IOB + 32'd4)   e.rdata = {16'h0000, sw_m};
         else if (addr == IOB + 32'd8)   e.rdata = tmr_val + 32'(cyc + 1 - tmr_edge);
      end
      sb.push_back(e);
      mem_w = wr; mem_rd = !wr; Addr_in = addr; cpu_wdata = wd; DMWType = sz;
      #1;
      chk({tag, ".ready_req"}, 32'(MIO_ready), 32'd0);
      chk({tag, ".we_req"}, 32'(ram_we), 32'(we_e));
      for (int b = 0; b < 4; b++) begin
         if (we_e[b]) chk({tag, ".wdata_lane"}, 32'(ram_wdata[8*b +: 8]), 32'(wd[8*(b-off) +: 8]));
      end
      n = 0; rdy = 1'b0;
      while (!rdy && n < 6) begin
         @(negedge clk);
         n++;
         if (MIO_ready) rdy = 1'b1;
         else chk({tag, ".we_wait"}, 32'(ram_we), 32'd0);
      end
      e = sb.pop_front();
      chk({tag, ".latency"}, 32'(n), 32'(e.lat));
      chk({tag, ".err_ack"}, 32'(err_misalign), 32'(e.err));
      chk({tag, ".we_ack"}, 32'(ram_we), 32'd0);
      if (!wr) chk({tag, ".rdata"}, cpu_rdata, e.rdata);
      mem_w = 1'b0; mem_rd = 1'b0;
      @(negedge clk);
      chk({tag, ".err_after"}, 32'(err_misalign), 32'd0);
      chk({tag, ".ready_idle"}, 32'(MIO_ready), 32'd1);
   endtask

   initial begin
      reset = 1'b0; mem_w = 1'b0; mem_rd = 1'b0; Addr_in = 32'h0;
      cpu_wdata = 32'h0; DMWType = 4'b1111; sw_in = 16'h0000;
      led_m = 16'h0000; sw_m = 16'h0000; tmr_val = 32'h0; tmr_edge = 0;
      repeat (3) @(negedge clk);
      chk("rst.ready", 32'(MIO_ready), 32'd1);
      chk("rst.we", 32'(ram_we), 32'd0);
      chk("rst.led", 32'(led_out), 32'd0);
      chk("rst.rdata", cpu_rdata, 32'd0);
      chk("rst.err", 32'(err_misalign), 32'd0);
      reset = 1'b1; tmr_val = 32'h0; tmr_edge = cyc;

      access("wst",   1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111);
      access("wld",   1'b0, 32'h10, 32'h0, 4'b1111);
      access("bst",   1'b1, 32'h13, 32'h0000_00AB, 4'b0001);
      access("wld2",  1'b0, 32'h10, 32'h0, 4'b1111);
      access("bld",   1'b0, 32'h13, 32'h0, 4'b0001);
      access("hld",   1'b0, 32'h12, 32'h0, 4'b0011);
      access("misld", 1'b0, 32'h12, 32'h0, 4'b1111);
      access("misst", 1'b1, 32'h11, 32'h0000_5555, 4'b0011);
      access("wld3",  1'b0, 32'h10, 32'h0, 4'b1111);
      access("hst",   1'b1, 32'h16, 32'h0000_C3D2, 4'b0011);
      access("hld2",  1'b0, 32'h16, 32'h0, 4'b0011);

      access("tst",   1'b1, IOB + 32'd8, 32'hFFFF_FFFE, 4'b1111);
      repeat (3) @(negedge clk);
      access("tld",   1'b0, IOB + 32'd8, 32'h0, 4'b1111);

      access("ledst", 1'b1, IOB, 32'h1234_5A5A, 4'b1111);
      chk("led.out", 32'(led_out), 32'(led_m));
      access("ledld", 1'b0, IOB, 32'h0, 4'b1111);

      sw_in = 16'h00F0; sw_m = 16'h00F0;
      repeat (3) @(negedge clk);
      access("swld",  1'b0, IOB + 32'd4, 32'h0, 4'b1111);
      access("swst",  1'b1, IOB + 32'd4, 32'hFFFF_FFFF, 4'b1111);
      access("swld2", 1'b0, IOB + 32'd4, 32'h0, 4'b1111);

      access("unst",  1'b1, 32'h8000_0000, 32'h1357_9BDF, 4'b1111);
      access("unld",  1'b0, 32'h8000_0000, 32'h0, 4'b1111);
      access("st20",  1'b1, 32'h20, 32'h1111_2222, 4'b1111);

      // Reset in the RD_WAIT cycle of a load.
      @(negedge clk);
      mem_rd = 1'b1; Addr_in = 32'h10; DMWType = 4'b1111;
      @(negedge clk);
      chk("rstld.ready_rdwait", 32'(MIO_ready), 32'd0);
      reset = 1'b0; mem_rd = 1'b0;
      @(negedge clk);
      chk("rstld.ready", 32'(MIO_ready), 32'd1);
      chk("rstld.we", 32'(ram_we), 32'd0);
      chk("rstld.rdata", cpu_rdata, 32'd0);
      chk("rstld.led", 32'(led_out), 32'd0);
      // Store request cycles while reset is held: must not write.
      mem_w = 1'b1; Addr_in = 32'h20; cpu_wdata = 32'hCAFE_F00D;
      #1;
      chk("rstst.we", 32'(ram_we), 32'd0);
      @(negedge clk);
      Addr_in = IOB;
      @(negedge clk);
      chk("rstst.led", 32'(led_out), 32'd0);
      mem_w = 1'b0;
      #1;
      chk("rstst.ready", 32'(MIO_ready), 32'd1);
      @(negedge clk);
      reset = 1'b1; tmr_val = 32'h0; tmr_edge = cyc; led_m = 16'h0000;

      access("tld_rst", 1'b0, IOB + 32'd8, 32'h0, 4'b1111);
      access("ld20",    1'b0, 32'h20, 32'h0, 4'b1111);
      access("ledld_rst", 1'b0, IOB, 32'h0, 4'b1111);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
